// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared constants and state encoding for serial_byte_loader
package loader_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  // Wide enough to hold DATA_WIDTH itself, which the parity frame needs
  localparam int DATA_WIDTH_BITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_SETUP = 2'd2,
    ST_STORE = 2'd3
  } state_t;

endpackage

// File: rtl/serial_byte_loader_if.sv
// rtl/serial_byte_loader_if.sv - serial bit stream in, latch-side word/store out
interface serial_byte_loader_if
  import loader_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

  logic                       bit_in;
  logic                       bit_valid;
  logic                       bit_ready;
  logic                       flush;
  logic [DATA_WIDTH-1:0]      data_out;
  logic                       store_out;
  logic [DATA_WIDTH_BITS-1:0] bit_count;
  logic                       word_done;
`ifdef PARITY_CHECK_EN
  logic                       parity_err;
`endif

  modport master (
    output bit_in, bit_valid, flush,
    input  bit_ready, data_out, store_out, bit_count, word_done
`ifdef PARITY_CHECK_EN
    , input parity_err
`endif
  );

  modport slave (
    input  bit_in, bit_valid, flush,
    output bit_ready, data_out, store_out, bit_count, word_done
`ifdef PARITY_CHECK_EN
    , output parity_err
`endif
  );

endinterface

// File: rtl/bit_counter.sv
// rtl/bit_counter.sv - up-counter with sync clear and terminal-count flag
module bit_counter
  import loader_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH_BITS
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] last,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

  assign tc = (count == last);

endmodule

// File: rtl/serial_byte_loader.sv
// rtl/serial_byte_loader.sv - deserialises bits into a word and pulses a clean store window
// Optional even-parity frame check: define PARITY_CHECK_EN.
module serial_byte_loader
  import loader_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int STORE_CYCLES = 2,
  parameter int MSB_FIRST    = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  serial_byte_loader_if.slave bus
);

  localparam int CW = DATA_WIDTH_BITS;
`ifdef PARITY_CHECK_EN
  localparam logic [CW-1:0] BIT_LAST = CW'(DATA_WIDTH);
`else
  localparam logic [CW-1:0] BIT_LAST = CW'(DATA_WIDTH - 1);
`endif
  localparam int SW = (STORE_CYCLES > 1) ? $clog2(STORE_CYCLES) : 1;
  localparam logic [SW-1:0] STORE_LAST = SW'(STORE_CYCLES - 1);

  state_t                state;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_base;
  logic [DATA_WIDTH-1:0] shift_next;
  logic [DATA_WIDTH-1:0] data_src;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  store_q;
  logic [CW-1:0]         bit_cnt;
  logic                  bit_tc;
  logic [SW-1:0]         store_cnt_unused;
  logic                  store_tc;
  logic                  ready;
  logic                  cnt_clear;
  logic                  cnt_en;
  logic                  shift_load;
  logic                  shift_clear;
  logic                  data_load;
  logic                  perr_set;

  // A new word always starts from an empty register
  assign shift_base = (state == ST_IDLE) ? '0 : shift_reg;
  assign shift_next = (MSB_FIRST != 0) ? {shift_base[DATA_WIDTH-2:0], bus.bit_in}
                                       : {bus.bit_in, shift_base[DATA_WIDTH-1:1]};

`ifdef PARITY_CHECK_EN
  logic parity_ok;
  logic perr_q;
  assign parity_ok = ~(^shift_reg ^ bus.bit_in);
  assign data_src  = shift_reg;
`else
  assign data_src  = shift_next;
`endif

  bit_counter #(.WIDTH(CW)) u_bit_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (cnt_clear),
    .enable  (cnt_en),
    .last    (BIT_LAST),
    .count   (bit_cnt),
    .tc      (bit_tc)
  );

  bit_counter #(.WIDTH(SW)) u_store_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   ((state != ST_STORE) || store_tc),
    .enable  (state == ST_STORE),
    .last    (STORE_LAST),
    .count   (store_cnt_unused),
    .tc      (store_tc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    ready       = 1'b0;
    cnt_clear   = 1'b0;
    cnt_en      = 1'b0;
    shift_load  = 1'b0;
    shift_clear = 1'b0;
    data_load   = 1'b0;
    perr_set    = 1'b0;
    case (state)
      ST_IDLE, ST_SHIFT: begin
        ready = 1'b1;
        if (bus.flush) begin
          cnt_clear   = 1'b1;
          shift_clear = 1'b1;
          state_next  = ST_IDLE;
        end else if (bus.bit_valid) begin
          if (bit_tc) begin
            cnt_clear = 1'b1;
`ifdef PARITY_CHECK_EN
            if (parity_ok) begin
              data_load  = 1'b1;
              state_next = ST_SETUP;
            end else begin
              perr_set    = 1'b1;
              shift_clear = 1'b1;
              state_next  = ST_IDLE;
            end
`else
            shift_load = 1'b1;
            data_load  = 1'b1;
            state_next = ST_SETUP;
`endif
          end else begin
            cnt_en     = 1'b1;
            shift_load = 1'b1;
            state_next = ST_SHIFT;
          end
        end
      end
      ST_SETUP: state_next = ST_STORE;
      ST_STORE: begin
        if (store_tc) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg <= '0;
      data_q    <= '0;
      store_q   <= 1'b0;
    end else begin
      if (shift_clear) begin
        shift_reg <= '0;
      end else if (shift_load) begin
        shift_reg <= shift_next;
      end
      if (data_load) begin
        data_q <= data_src;
      end
      // Registered from the next state so the strobe is glitch-free
      store_q <= (state_next == ST_STORE);
    end
  end

`ifdef PARITY_CHECK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_set;
    end
  end
  assign bus.parity_err = perr_q;
`endif

  assign bus.bit_ready = ready;
  assign bus.data_out  = data_q;
  assign bus.store_out = store_q;
  assign bus.bit_count = bit_cnt;
  assign bus.word_done = (state == ST_STORE) && store_tc;

endmodule
